// File: rtl/lv_owt_req_sched_pkg.sv
// Shared types and constants for the LV-side one-wire link request scheduler.
package lv_owt_req_sched_pkg;

   typedef struct packed {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] wdata;
   } owt_cmd_t;

   typedef enum logic [1:0] {
      SrcFlt = 2'd0,
      SrcSpi = 2'd1,
      SrcAdc = 2'd2
   } req_src_e;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StWait,
      StRsp
   } sched_st_e;

   localparam logic [6:0] FLT_ADDR_DEF = 7'h10;
   localparam logic [6:0] ADC_ADDR_DEF = 7'h20;

   function automatic owt_cmd_t rd_cmd(input logic [6:0] addr);
      owt_cmd_t c;
      c.rw    = 1'b0;
      c.addr  = addr;
      c.wdata = 8'h00;
      return c;
   endfunction

endpackage

// File: rtl/lv_owt_req_sched_poll_tmr.sv
// Periodic ADC poll request generator: free-running period counter plus a single pending flag.
module lv_owt_req_sched_poll_tmr #(
   parameter int unsigned POLL_PERIOD = 2000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_pend
);

   localparam int unsigned CW = $clog2(POLL_PERIOD);
   localparam logic [CW-1:0] CNT_LAST = CW'(POLL_PERIOD - 1);

   logic [CW-1:0] r_cnt;
   logic          r_pend;

   always_ff @(posedge i_clk) begin
      if (i_rst || !i_en) begin
         r_cnt  <= '0;
         r_pend <= 1'b0;
      end else begin
         if (i_clr) begin
            r_pend <= 1'b0;
         end
         // A new period expiring in the same cycle as a grant re-arms the flag.
         if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_pend <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_pend = r_pend;

endmodule

// File: rtl/lv_owt_req_sched.sv
// Arbitrates fault, SPI and ADC-poll requests onto the single OWT link; one transaction in flight.
module lv_owt_req_sched
   import lv_owt_req_sched_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 2000,
   parameter int unsigned RSP_TMO     = 255,
   parameter int unsigned MAX_RETRY   = 2,
   parameter logic [6:0]  FLT_ADDR    = FLT_ADDR_DEF,
   parameter logic [6:0]  ADC_ADDR    = ADC_ADDR_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flt_req,
   input  logic        i_spi_req_vld,
   input  logic [15:0] i_spi_req_cmd,
   output logic        o_spi_req_rdy,
   input  logic        i_poll_en,
   output logic        o_tx_vld,
   output logic [15:0] o_tx_cmd,
   input  logic        i_tx_rdy,
   input  logic        i_rx_vld,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_crc_err,
   output logic        o_rsp_vld,
   output logic [1:0]  o_rsp_src,
   output logic [7:0]  o_rsp_data,
   output logic        o_rsp_err,
   output logic        o_busy,
   output logic        o_tmo_pls
);

   localparam int unsigned TW = $clog2(RSP_TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(RSP_TMO - 1);
   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

   sched_st_e     r_st;
   owt_cmd_t      r_cmd;
   req_src_e      r_src;
   logic [2:0]    r_retry;
   logic [TW-1:0] r_tmo_cnt;
   logic          r_tx_vld;
   logic          r_rsp_vld;
   logic [7:0]    r_rsp_data;
   logic          r_rsp_err;
   logic          r_tmo_pls;
   logic          r_flt_pend;

   logic          w_idle;
   logic          w_flt;
   logic          w_gnt;
   logic          w_poll_pend;
   req_src_e      w_src;
   owt_cmd_t      w_cmd;

   lv_owt_req_sched_poll_tmr #(
      .POLL_PERIOD(POLL_PERIOD)
   ) u_poll_tmr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_poll_en),
      .i_clr  (w_gnt && (w_src == SrcAdc)),
      .o_pend (w_poll_pend)
   );

   // A fault pulse arriving in an idle cycle competes immediately, not one cycle late.
   assign w_idle = (r_st == StIdle) && !i_rst;
   assign w_flt  = r_flt_pend || i_flt_req;
   assign w_gnt  = w_idle && (w_flt || i_spi_req_vld || w_poll_pend);

   always_comb begin
      w_src = SrcFlt;
      w_cmd = rd_cmd(FLT_ADDR);
      if (!w_flt && i_spi_req_vld) begin
         w_src = SrcSpi;
         w_cmd = owt_cmd_t'(i_spi_req_cmd);
      end else if (!w_flt) begin
         w_src = SrcAdc;
         w_cmd = rd_cmd(ADC_ADDR);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_st       <= StIdle;
         r_cmd      <= '0;
         r_src      <= SrcFlt;
         r_retry    <= '0;
         r_tmo_cnt  <= '0;
         r_tx_vld   <= 1'b0;
         r_rsp_vld  <= 1'b0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_tmo_pls  <= 1'b0;
         r_flt_pend <= 1'b0;
      end else begin
         r_rsp_vld <= 1'b0;
         r_tmo_pls <= 1'b0;
         if (i_flt_req) begin
            r_flt_pend <= 1'b1;
         end
         if (w_gnt && (w_src == SrcFlt)) begin
            r_flt_pend <= 1'b0;
         end
         unique case (r_st)
            StIdle: begin
               if (w_gnt) begin
                  r_st     <= StSend;
                  r_cmd    <= w_cmd;
                  r_src    <= w_src;
                  r_retry  <= '0;
                  r_tx_vld <= 1'b1;
               end
            end
            StSend: begin
               if (i_tx_rdy) begin
                  r_st      <= StWait;
                  r_tx_vld  <= 1'b0;
                  r_tmo_cnt <= '0;
               end
            end
            StWait: begin
               if (i_rx_vld && !i_rx_crc_err) begin
                  r_st       <= StRsp;
                  r_rsp_vld  <= 1'b1;
                  r_rsp_data <= i_rx_data;
                  r_rsp_err  <= 1'b0;
               end else if (i_rx_vld || (r_tmo_cnt == TMO_LAST)) begin
                  r_tmo_pls <= !i_rx_vld;
                  if (r_retry < RETRY_MAX) begin
                     r_retry  <= r_retry + 3'd1;
                     r_st     <= StSend;
                     r_tx_vld <= 1'b1;
                  end else begin
                     r_st       <= StRsp;
                     r_rsp_vld  <= 1'b1;
                     r_rsp_err  <= 1'b1;
                     r_rsp_data <= i_rx_vld ? i_rx_data : 8'h00;
                  end
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            StRsp: begin
               r_st <= StIdle;
            end
            default: begin
               r_st <= StIdle;
            end
         endcase
      end
   end

   assign o_spi_req_rdy = w_gnt && (w_src == SrcSpi);
   assign o_tx_vld      = r_tx_vld;
   assign o_tx_cmd      = r_cmd;
   assign o_rsp_vld     = r_rsp_vld;
   assign o_rsp_src     = r_src;
   assign o_rsp_data    = r_rsp_data;
   assign o_rsp_err     = r_rsp_err;
   assign o_busy        = (r_st != StIdle);
   assign o_tmo_pls     = r_tmo_pls;

endmodule

// File: tb/tb_lv_owt_req_sched.sv
// Directed bench for lv_owt_req_sched with POLL_PERIOD=8, RSP_TMO=16, MAX_RETRY=2.
module tb_lv_owt_req_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flt_req = 1'b0;
   logic        spi_vld = 1'b0;
   logic [15:0] spi_cmd = 16'h0000;
   logic        spi_rdy;
   logic        poll_en = 1'b0;
   logic        tx_vld;
   logic [15:0] tx_cmd;
   logic        tx_rdy = 1'b0;
   logic        rx_vld = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_crc = 1'b0;
   logic        rsp_vld;
   logic [1:0]  rsp_src;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        busy;
   logic        tmo_pls;

   int total = 0;
   int bad = 0;
   int n_send = 0;
   int n_tmo = 0;
   int n_rsp = 0;
   int n_rdy = 0;

   lv_owt_req_sched #(
      .POLL_PERIOD(8),
      .RSP_TMO    (16),
      .MAX_RETRY  (2)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_flt_req     (flt_req),
      .i_spi_req_vld (spi_vld),
      .i_spi_req_cmd (spi_cmd),
      .o_spi_req_rdy (spi_rdy),
      .i_poll_en     (poll_en),
      .o_tx_vld      (tx_vld),
      .o_tx_cmd      (tx_cmd),
      .i_tx_rdy      (tx_rdy),
      .i_rx_vld      (rx_vld),
      .i_rx_data     (rx_data),
      .i_rx_crc_err  (rx_crc),
      .o_rsp_vld     (rsp_vld),
      .o_rsp_src     (rsp_src),
      .o_rsp_data    (rsp_data),
      .o_rsp_err     (rsp_err),
      .o_busy        (busy),
      .o_tmo_pls     (tmo_pls)
   );

   always #5 clk = ~clk;

   // Event counters sampled on the active edge, where handshakes actually complete.
   always @(posedge clk) begin
      if (tx_vld && tx_rdy) n_send++;
      if (tmo_pls) n_tmo++;
      if (rsp_vld) n_rsp++;
      if (spi_rdy) n_rdy++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic wait_rsp(input string tag, input int lim);
      logic got;
      got = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (rsp_vld) begin
            got = 1'b1;
            break;
         end
      end
      chk(tag, {31'd0, got}, 32'd1);
   endtask

   // From the first SEND cycle: accept, one WAIT cycle, clean reply; returns in RSP.
   task automatic do_txn(input logic [7:0] d);
      cyc();
      tx_rdy = 1'b1;
      cyc();
      tx_rdy = 1'b0;
      cyc();
      rx_vld = 1'b1;
      rx_data = d;
      cyc();
      rx_vld = 1'b0;
   endtask

   int b_send, b_tmo, b_rsp, b_rdy, n;

   initial begin
      // Reset
      rst = 1'b1;
      repeat (3) cyc();
      look();
      chk("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
      chk("rst_tx_cmd", {16'd0, tx_cmd}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp", {22'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, 32'd0);
      chk("rst_misc", {30'd0, spi_rdy, tmo_pls}, 32'd0);
      cyc();
      rst = 1'b0;
      cyc();

      // 1: SPI write, accept after 2 cycles, reply after 10
      b_rdy = n_rdy;
      spi_vld = 1'b1;
      spi_cmd = 16'h85A5;
      look();
      chk("t1_spi_rdy", {31'd0, spi_rdy}, 32'd1);
      cyc();
      spi_vld = 1'b0;
      look();
      chk("t1_tx_vld", {31'd0, tx_vld}, 32'd1);
      chk("t1_tx_cmd", {16'd0, tx_cmd}, 32'h85A5);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      cyc();
      tx_rdy = 1'b1;
      cyc();
      tx_rdy = 1'b0;
      look();
      chk("t1_tx_drop", {31'd0, tx_vld}, 32'd0);
      repeat (9) cyc();
      rx_vld = 1'b1;
      rx_data = 8'h5A;
      cyc();
      rx_vld = 1'b0;
      look();
      chk("t1_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd1, 8'h5A, 1'b0});
      cyc();
      look();
      chk("t1_idle", {30'd0, busy, rsp_vld}, 32'd0);
      chk("t1_rdy_cnt", n_rdy - b_rdy, 32'd1);

      // 2: fault request and SPI valid in the same cycle
      cyc();
      b_rdy = n_rdy;
      flt_req = 1'b1;
      spi_vld = 1'b1;
      spi_cmd = 16'h0312;
      look();
      chk("t2_spi_blocked", {31'd0, spi_rdy}, 32'd0);
      cyc();
      flt_req = 1'b0;
      look();
      chk("t2_flt_cmd", {16'd0, tx_cmd}, 32'h1000);
      do_txn(8'h77);
      look();
      chk("t2_flt_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd0, 8'h77, 1'b0});
      chk("t2_no_rdy_yet", n_rdy - b_rdy, 32'd0);
      cyc();
      look();
      chk("t2_spi_rdy", {31'd0, spi_rdy}, 32'd1);
      cyc();
      spi_vld = 1'b0;
      look();
      chk("t2_spi_cmd", {16'd0, tx_cmd}, 32'h0312);
      do_txn(8'h11);
      look();
      chk("t2_spi_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd1, 8'h11, 1'b0});
      cyc();

      // 3: no reply at all -> 3 sends, 3 timeouts, error with zero data
      b_send = n_send;
      b_tmo = n_tmo;
      spi_vld = 1'b1;
      spi_cmd = 16'h0505;
      tx_rdy = 1'b1;
      cyc();
      spi_vld = 1'b0;
      wait_rsp("t3_rsp_seen", 80);
      chk("t3_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd1, 8'h00, 1'b1});
      cyc();
      tx_rdy = 1'b0;
      look();
      chk("t3_sends", n_send - b_send, 32'd3);
      chk("t3_tmos", n_tmo - b_tmo, 32'd3);
      cyc();

      // 4: CRC error then clean reply
      b_send = n_send;
      b_tmo = n_tmo;
      spi_vld = 1'b1;
      spi_cmd = 16'h0606;
      tx_rdy = 1'b1;
      cyc();
      spi_vld = 1'b0;
      cyc();
      rx_vld = 1'b1;
      rx_crc = 1'b1;
      rx_data = 8'hEE;
      cyc();
      rx_vld = 1'b0;
      rx_crc = 1'b0;
      cyc();
      rx_vld = 1'b1;
      rx_data = 8'h3C;
      cyc();
      rx_vld = 1'b0;
      tx_rdy = 1'b0;
      look();
      chk("t4_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd1, 8'h3C, 1'b0});
      chk("t4_sends", n_send - b_send, 32'd2);
      cyc();
      look();
      chk("t4_tmos", n_tmo - b_tmo, 32'd0);
      cyc();

      // 4b: CRC error on every attempt -> error carrying the last bad data
      b_send = n_send;
      spi_vld = 1'b1;
      spi_cmd = 16'h0707;
      tx_rdy = 1'b1;
      cyc();
      spi_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         rx_vld = 1'b1;
         rx_crc = 1'b1;
         rx_data = 8'hA1 + 8'(k);
         cyc();
         rx_vld = 1'b0;
         rx_crc = 1'b0;
      end
      tx_rdy = 1'b0;
      look();
      chk("t4b_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd1, 8'hA3, 1'b1});
      chk("t4b_sends", n_send - b_send, 32'd3);
      cyc();

      // 4c: reply lands exactly in the timeout-terminal cycle
      b_tmo = n_tmo;
      spi_vld = 1'b1;
      spi_cmd = 16'h0808;
      tx_rdy = 1'b1;
      cyc();
      spi_vld = 1'b0;
      cyc();
      tx_rdy = 1'b0;
      repeat (15) cyc();
      rx_vld = 1'b1;
      rx_data = 8'h42;
      cyc();
      rx_vld = 1'b0;
      look();
      chk("t4c_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd1, 8'h42, 1'b0});
      cyc();
      look();
      chk("t4c_tmos", n_tmo - b_tmo, 32'd0);
      cyc();

      // 5: ADC polling every 8 cycles, busy link does not stack polls
      poll_en = 1'b1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n++;
         if (tx_vld) break;
      end
      chk("t5_first_poll_lat", n, 32'd10);
      chk("t5_adc_cmd", {16'd0, tx_cmd}, 32'h2000);
      cyc();
      repeat (19) cyc();
      tx_rdy = 1'b1;
      cyc();
      tx_rdy = 1'b0;
      cyc();
      rx_vld = 1'b1;
      rx_data = 8'h99;
      cyc();
      rx_vld = 1'b0;
      look();
      chk("t5_rsp", {21'd0, rsp_vld, rsp_src, rsp_data, rsp_err}, {21'd0, 1'b1, 2'd2, 8'h99, 1'b0});
      cyc();
      look();
      chk("t5_idle_gap", {31'd0, busy}, 32'd0);
      cyc();
      tx_rdy = 1'b1;
      look();
      chk("t5_pend_poll", {15'd0, tx_vld, tx_cmd}, {15'd0, 1'b1, 16'h2000});
      cyc();
      tx_rdy = 1'b0;
      rx_vld = 1'b1;
      rx_data = 8'h98;
      cyc();
      rx_vld = 1'b0;
      cyc();
      cyc();
      look();
      chk("t5_no_stack_a", {31'd0, busy}, 32'd0);
      cyc();
      look();
      chk("t5_no_stack_b", {31'd0, busy}, 32'd0);
      cyc();
      look();
      chk("t5_no_stack_c", {31'd0, busy}, 32'd0);
      cyc();
      look();
      chk("t5_next_period", {15'd0, tx_vld, tx_cmd}, {15'd0, 1'b1, 16'h2000});
      cyc();
      poll_en = 1'b0;
      do_txn(8'h01);
      cyc();
      repeat (12) cyc();
      look();
      chk("t5_poll_off", {31'd0, busy}, 32'd0);
      cyc();

      // 6: reset while waiting for the reply
      b_rsp = n_rsp;
      spi_vld = 1'b1;
      spi_cmd = 16'h0101;
      cyc();
      spi_vld = 1'b0;
      tx_rdy = 1'b1;
      cyc();
      tx_rdy = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      look();
      chk("t6_after_rst", {29'd0, busy, tx_vld, rsp_vld}, 32'd0);
      cyc();
      rx_vld = 1'b1;
      rx_data = 8'h55;
      cyc();
      rx_vld = 1'b0;
      cyc();
      look();
      chk("t6_late_rx", {31'd0, busy}, 32'd0);
      chk("t6_no_rsp", n_rsp - b_rsp, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
